// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, start/data/parity/stop
// sampling at bit centres, output byte and flags held behind ap_valid/ap_ready.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       ap_rstn,
   input  logic       rx,
   input  logic       pairty,
   input  logic       ap_ready,
   output logic       ap_valid,
   output logic [7:0] data,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, STAR, TRSF, PARI, STOP, WAIT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          perr_q, perr_d;
   logic [7:0]    data_q, data_d;
   logic          pe_q, pe_d;
   logic          fe_q, fe_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;
   logic          rx_s;
   logic          sample;
   logic          commit;
   logic          hs;

   assign rx_s = sync_q[1];
   assign hs   = valid_q & ap_ready;

   // The start bit is sampled half a bit after t0; every later sample is one full bit apart.
   assign sample = (state_q == STAR) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      commit  = 1'b0;
      if (sample) cnt_d = '0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = STAR;
         end
         STAR: begin
            if (sample) begin
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = TRSF;
                  bit_d   = '0;
                  perr_d  = 1'b0;
               end
            end
         end
         TRSF: begin
            if (sample) begin
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = pairty ? PARI : STOP;
            end
         end
         PARI: begin
            if (sample) begin
               perr_d  = rx_s ^ (^shift_q);
               state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               commit  = 1'b1;
               state_d = rx_s ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A commit coinciding with a handshake replaces the held byte without flagging overrun.
   always_comb begin
      data_d  = data_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (hs) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (commit) begin
         if (!valid_q || hs) begin
            data_d  = shift_q;
            pe_d    = perr_q;
            fe_d    = ~rx_s;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!ap_rstn) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         data_q  <= '0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], rx};
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         data_q  <= data_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign ap_valid   = valid_q;
   assign data       = data_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16 with hand-computed bytes, flags and timing.
module tb_uart_rx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       ap_rstn = 1'b0;
   logic       rx = 1'b1;
   logic       pairty = 1'b0;
   logic       ap_ready = 1'b1;
   logic       ap_valid;
   logic [7:0] data;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.OVERSAMPLE(OS)) dut (
      .clk       (clk),
      .ap_rstn   (ap_rstn),
      .rx        (rx),
      .pairty    (pairty),
      .ap_ready  (ap_ready),
      .ap_valid  (ap_valid),
      .data      (data),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   int   vcount = 0;
   int   rises = 0;
   int   rise_cyc = -1;
   logic prev_v = 1'b0;
   logic [7:0] cap_data = '0;
   logic cap_pe = 1'b0;
   logic cap_fe = 1'b0;

   always @(negedge clk) begin
      if (ap_valid) begin
         vcount = vcount + 1;
         if (!prev_v) begin
            rises    = rises + 1;
            rise_cyc = cyc;
            cap_data = data;
            cap_pe   = parity_err;
            cap_fe   = frame_err;
         end
      end
      prev_v = ap_valid;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks = checks + 1;
      if (got != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // e = cycle count right after the edge at which the start bit was driven.
   task automatic send(input logic [7:0] b, input logic use_par, input logic par_bit,
                       input logic stop_bit, input int abort_bit, output int e);
      @(posedge clk); #1;
      e  = cyc;
      rx = 1'b0;
      repeat (OS) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == abort_bit) begin
            repeat (OS / 2) @(posedge clk);
            #1;
            ap_rstn = 1'b0;
            rx      = 1'b1;
            @(posedge clk); #1;
            ap_rstn = 1'b1;
            return;
         end
         repeat (OS) @(posedge clk);
         #1;
      end
      if (use_par) begin
         rx = par_bit;
         repeat (OS) @(posedge clk);
         #1;
      end
      rx = stop_bit;
      repeat (OS) @(posedge clk);
      #1;
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1;
      ap_ready = 1'b1;
      @(posedge clk); #1;
      ap_ready = 1'b0;
   endtask

   int e, v0, r0, e2;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(ap_valid), 0);
      check("rst_data", int'(data), 0);
      check("rst_flags", int'({parity_err, frame_err, overrun}), 0);
      ap_rstn = 1'b1;
      repeat (5) @(posedge clk);

      // Basic byte
      v0 = vcount;
      send(8'hA5, 1'b0, 1'b0, 1'b1, -1, e);
      check("basic_rise", rise_cyc, e + 155);
      check("basic_data", int'(cap_data), 'hA5);
      check("basic_flags", int'({cap_pe, cap_fe, overrun}), 0);
      check("basic_1cyc", vcount - v0, 1);
      check("basic_drop", int'(ap_valid), 0);

      // Parity
      pairty = 1'b1;
      send(8'h3C, 1'b1, 1'b0, 1'b1, -1, e);
      check("par0_rise", rise_cyc, e + 171);
      check("par0_pe", int'(cap_pe), 0);
      send(8'h3C, 1'b1, 1'b1, 1'b1, -1, e);
      check("par1_pe", int'(cap_pe), 1);
      check("par1_data", int'(cap_data), 'h3C);
      send(8'h01, 1'b1, 1'b1, 1'b1, -1, e);
      check("par01_pe", int'(cap_pe), 0);
      check("par01_data", int'(cap_data), 'h01);
      pairty = 1'b0;
      repeat (4) @(posedge clk);

      // False start
      r0 = rises;
      @(posedge clk); #1;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("false_none", rises - r0, 0);
      send(8'h5A, 1'b0, 1'b0, 1'b1, -1, e);
      check("after_false_rise", rise_cyc, e + 155);
      check("after_false_data", int'(cap_data), 'h5A);

      // Frame error then break
      r0 = rises;
      v0 = vcount;
      send(8'hFF, 1'b0, 1'b0, 1'b0, -1, e);
      repeat (300) @(posedge clk);
      #1;
      check("brk_rises", rises - r0, 1);
      check("brk_vcyc", vcount - v0, 1);
      check("brk_fe", int'(cap_fe), 1);
      check("brk_data", int'(cap_data), 'hFF);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      send(8'h11, 1'b0, 1'b0, 1'b1, -1, e);
      check("post_brk_data", int'(cap_data), 'h11);
      check("post_brk_fe", int'(cap_fe), 0);

      // Overrun
      ap_ready = 1'b0;
      send(8'h12, 1'b0, 1'b0, 1'b1, -1, e);
      send(8'h34, 1'b0, 1'b0, 1'b1, -1, e);
      check("ovr_valid", int'(ap_valid), 1);
      check("ovr_data", int'(data), 'h12);
      check("ovr_flag", int'(overrun), 1);
      pulse_ready();
      check("ovr_hs_valid", int'(ap_valid), 0);
      check("ovr_hs_flag", int'(overrun), 0);

      // Commit coinciding with handshake
      send(8'h12, 1'b0, 1'b0, 1'b1, -1, e);
      fork
         send(8'h34, 1'b0, 1'b0, 1'b1, -1, e2);
         begin
            @(posedge clk); #1;
            repeat (154) @(posedge clk);
            #1;
            ap_ready = 1'b1;
            @(posedge clk); #1;
            ap_ready = 1'b0;
            check("coin_valid", int'(ap_valid), 1);
         end
      join
      check("coin_data", int'(data), 'h34);
      check("coin_ovr", int'(overrun), 0);
      pulse_ready();
      check("coin_clear", int'(ap_valid), 0);

      // Reset mid-frame
      send(8'h99, 1'b0, 1'b0, 1'b1, -1, e);
      check("pre_rst_valid", int'(ap_valid), 1);
      r0 = rises;
      send(8'hC3, 1'b0, 1'b0, 1'b1, 4, e);
      check("mid_rst_valid", int'(ap_valid), 0);
      check("mid_rst_data", int'(data), 0);
      check("mid_rst_flags", int'({parity_err, frame_err, overrun}), 0);
      repeat (200) @(posedge clk);
      #1;
      check("mid_rst_none", rises - r0, 0);
      ap_ready = 1'b1;
      send(8'h7E, 1'b0, 1'b0, 1'b1, -1, e);
      check("post_rst_rise", rise_cyc, e + 155);
      check("post_rst_data", int'(cap_data), 'h7E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
